// File: rtl/risc8_pkg.sv
// rtl/risc8_pkg.sv - shared types and I/O window map for the risc8 memory responder
package risc8_pkg;

  typedef logic [7:0] word_t;

  // I/O window base and register offsets relative to it
  localparam word_t RISC8_IO_BASE   = 8'hF0;
  localparam word_t RISC8_IO_STATUS = 8'h00;
  localparam word_t RISC8_IO_TXCNT  = 8'h01;
  localparam word_t RISC8_IO_RXCNT  = 8'h02;
  localparam word_t RISC8_IO_RXDATA = 8'h0E;
  localparam word_t RISC8_IO_TXDATA = 8'h0F;

  localparam int RISC8_STAT_TX_FULL    = 0;
  localparam int RISC8_STAT_TX_EMPTY   = 1;
  localparam int RISC8_STAT_RX_NONEMPTY = 2;
  localparam int RISC8_STAT_TX_DROP    = 3;
  localparam int RISC8_STAT_RX_DROP    = 4;

endpackage

// File: rtl/risc8_fifo.sv
// rtl/risc8_fifo.sv - synchronous byte FIFO with combinational head and occupancy count
module risc8_fifo
  import risc8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  word_t                  push_data,
  input  logic                   pop,
  output word_t                  head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  word_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push_ok;
  logic           pop_ok;

  // Full/empty come from the pre-edge count, so a push to a full FIFO is lost
  // even when a pop happens in the same cycle.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/risc8_mem_resp.sv
// rtl/risc8_mem_resp.sv - risc8 RAM-port responder: data RAM plus TX/RX byte FIFO I/O window
module risc8_mem_resp
  import risc8_pkg::*;
#(
  parameter int    RAM_WORDS = 240,
  parameter word_t IO_BASE   = RISC8_IO_BASE,
  parameter int    TX_DEPTH  = 4,
  parameter int    RX_DEPTH  = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  word_t ram_addr,
  input  logic  ram_wr_en,
  input  logic  ram_rd_en,
  input  word_t ram_wr_data,
  output word_t ram_rd_data,
  output word_t tx_data,
  output logic  tx_valid,
  input  logic  tx_ready,
  input  word_t rx_data,
  input  logic  rx_valid,
  output logic  rx_ready
);

  localparam logic [8:0] RAM_LIM = 9'(RAM_WORDS);

  word_t ram [RAM_WORDS];

  logic  in_ram;
  logic  in_io;
  word_t io_off;
  logic  rd_only;

  word_t                      tx_head;
  logic                       tx_full;
  logic                       tx_empty;
  logic [$clog2(TX_DEPTH):0]  tx_count;
  word_t                      rx_head;
  logic                       rx_full;
  logic                       rx_empty;
  logic [$clog2(RX_DEPTH):0]  rx_count;

  logic  tx_push_req;
  logic  tx_push;
  logic  tx_pop;
  logic  rx_pop_req;
  logic  rx_pop;
  logic  rx_push;
  logic  tx_drop;
  logic  rx_drop;
  logic  tx_drop_set;
  logic  rx_drop_set;
  logic  tx_drop_clr;
  logic  rx_drop_clr;
  word_t status;

  assign in_ram  = ({1'b0, ram_addr} < RAM_LIM);
  assign in_io   = (ram_addr >= IO_BASE);
  assign io_off  = ram_addr - IO_BASE;
  // A simultaneous write wins over the read, so the read side effect is suppressed.
  assign rd_only = ram_rd_en && !ram_wr_en;

  assign tx_push_req = ram_wr_en && in_io && (io_off == RISC8_IO_TXDATA);
  assign tx_push     = tx_push_req && !tx_full;
  assign tx_drop_set = tx_push_req && tx_full;
  assign tx_pop      = tx_valid && tx_ready;

  assign rx_pop_req  = rd_only && in_io && (io_off == RISC8_IO_RXDATA);
  assign rx_pop      = rx_pop_req && !rx_empty;
  assign rx_drop_set = rx_pop_req && rx_empty;
  assign rx_push     = rx_valid && rx_ready;

  assign tx_drop_clr = ram_wr_en && in_io && (io_off == RISC8_IO_STATUS) && ram_wr_data[RISC8_STAT_TX_DROP];
  assign rx_drop_clr = ram_wr_en && in_io && (io_off == RISC8_IO_STATUS) && ram_wr_data[RISC8_STAT_RX_DROP];

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_head;
  assign rx_ready = !rx_full && !rst;

  risc8_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (ram_wr_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  risc8_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  always_comb begin
    status                         = '0;
    status[RISC8_STAT_TX_FULL]     = tx_full;
    status[RISC8_STAT_TX_EMPTY]    = tx_empty;
    status[RISC8_STAT_RX_NONEMPTY] = !rx_empty;
    status[RISC8_STAT_TX_DROP]     = tx_drop;
    status[RISC8_STAT_RX_DROP]     = rx_drop;
  end

  // Asynchronous read: the single-cycle core consumes ram_rd_data in the same cycle.
  always_comb begin
    ram_rd_data = '0;
    if (in_ram) begin
      ram_rd_data = ram[ram_addr];
    end else if (in_io) begin
      case (io_off)
        RISC8_IO_STATUS: ram_rd_data = status;
        RISC8_IO_TXCNT:  ram_rd_data = 8'(tx_count);
        RISC8_IO_RXCNT:  ram_rd_data = 8'(rx_count);
        RISC8_IO_RXDATA: ram_rd_data = rx_empty ? 8'h00 : rx_head;
        default:         ram_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && ram_wr_en && in_ram) begin
      ram[ram_addr] <= ram_wr_data;
    end
  end

  // Sticky drop flags: a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_drop <= 1'b0;
      rx_drop <= 1'b0;
    end else begin
      if (tx_drop_set)      tx_drop <= 1'b1;
      else if (tx_drop_clr) tx_drop <= 1'b0;
      if (rx_drop_set)      rx_drop <= 1'b1;
      else if (rx_drop_clr) rx_drop <= 1'b0;
    end
  end

endmodule
